// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin frame scheduler in front of the mac UDP transmitter.
// Grants one whole frame at a time to a requesting channel. It drives the mac
// frame request, length, IPv4 identification and payload bytes. It also pops
// the granted channel's FWFT source on each byte request.
//
// Ports:
//   I_clk50m, I_rst        RMII clock, synchronous active-high reset
//   I_ch_req/len/data      per-channel frame request, payload length, current byte
//   O_ch_pop               same-cycle pop strobe to the granted channel
//   O_en/O_dataLen/O_ipv4sign/O_data/O_grant   mac frame controls and payload
//   I_busy, I_byte_req     mac status and byte-request strobe
//   O_active, O_err, O_frames   activity flag, error pulse, completed-frame count
module udp_tx_sched #(
  parameter int unsigned CH_NUM        = 4,
  parameter int unsigned LEN_W         = 16,
  parameter int unsigned MAX_LEN       = 1472,
  parameter logic [15:0] IDENT_INIT    = 16'h0148,
  parameter logic [7:0]  PAD_BYTE      = 8'h00,
  parameter int unsigned START_TIMEOUT = 1023,
  parameter int unsigned IFG_CYCLES    = 48
) (
  input  logic                    I_clk50m,
  input  logic                    I_rst,
  input  logic [CH_NUM-1:0]       I_ch_req,
  input  logic [CH_NUM*LEN_W-1:0] I_ch_len,
  input  logic [CH_NUM*8-1:0]     I_ch_data,
  output logic [CH_NUM-1:0]       O_ch_pop,
  output logic                    O_en,
  output logic [LEN_W-1:0]        O_dataLen,
  output logic [15:0]             O_ipv4sign,
  output logic [7:0]              O_data,
  output logic [3:0]              O_grant,
  input  logic                    I_busy,
  input  logic                    I_byte_req,
  output logic                    O_active,
  output logic                    O_err,
  output logic [31:0]             O_frames
);

  typedef enum logic [2:0] {StIdle, StArb, StStart, StStream, StGap} state_e;

  state_e           r_state;
  logic [3:0]       r_last_grant;
  logic [3:0]       r_grant;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_sent;
  logic [15:0]      r_ident;
  logic [15:0]      r_ipv4sign;
  logic [31:0]      r_timer;  // START timeout, then reused as the GAP counter
  logic             r_en;
  logic [7:0]       r_data;
  logic             r_err;
  logic [31:0]      r_frames;

  logic [15:0]      w_req;
  logic             w_found;
  logic [3:0]       w_gnt;
  logic [3:0]       w_idx;
  logic [LEN_W-1:0] w_len_raw;
  logic [LEN_W-1:0] w_len;
  logic [7:0]       w_byte;
  logic             w_take;
  logic [LEN_W-1:0] w_sent_nxt;

  // Cyclic search for the first requester after the last served channel.
  always_comb begin
    w_req             = '0;
    w_req[CH_NUM-1:0] = I_ch_req;
    w_found           = 1'b0;
    w_gnt             = '0;
    w_idx             = '0;
    for (int unsigned i = 1; i <= CH_NUM; i++) begin
      w_idx = 4'((32'(r_last_grant) + i) % CH_NUM);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  // A byte is taken from the source only while the frame still owes bytes.
  assign w_take     = (r_state == StStream) && I_byte_req && (r_sent < r_len);
  assign w_sent_nxt = w_take ? r_sent + LEN_W'(1) : r_sent;

  always_comb begin
    w_len_raw = '0;
    w_byte    = PAD_BYTE;
    O_ch_pop  = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (4'(c) == w_gnt) begin
        w_len_raw = I_ch_len[c*LEN_W +: LEN_W];
      end
      if (4'(c) == r_grant) begin
        w_byte      = I_ch_data[c*8 +: 8];
        O_ch_pop[c] = w_take;
      end
    end
  end

  assign w_len = (w_len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : w_len_raw;

  always_ff @(posedge I_clk50m) begin
    if (I_rst) begin
      r_state      <= StIdle;
      r_last_grant <= 4'(CH_NUM - 1);
      r_grant      <= '0;
      r_len        <= '0;
      r_sent       <= '0;
      r_ident      <= IDENT_INIT;
      r_ipv4sign   <= IDENT_INIT;
      r_timer      <= '0;
      r_en         <= 1'b0;
      r_data       <= PAD_BYTE;
      r_err        <= 1'b0;
      r_frames     <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (|I_ch_req) r_state <= StArb;
        end
        StArb: begin
          if (!w_found) begin
            // Requester withdrew before arbitration: nothing to grant.
            r_state <= StIdle;
          end else begin
            r_grant    <= w_gnt;
            r_len      <= w_len;
            r_sent     <= '0;
            r_timer    <= '0;
            r_ipv4sign <= r_ident;
            if (w_len == '0) begin
              r_err        <= 1'b1;
              r_last_grant <= w_gnt;
              r_state      <= StIdle;
            end else begin
              r_en    <= 1'b1;
              r_state <= StStart;
            end
          end
        end
        StStart: begin
          if (I_busy) begin
            r_en    <= 1'b0;
            r_state <= StStream;
          end else if (r_timer == START_TIMEOUT - 1) begin
            r_en         <= 1'b0;
            r_err        <= 1'b1;
            r_last_grant <= r_grant;
            r_state      <= StIdle;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        StStream: begin
          if (I_byte_req) begin
            if (w_take) begin
              r_data <= w_byte;
            end else begin
              r_data <= PAD_BYTE;
              r_err  <= 1'b1;
            end
          end
          r_sent <= w_sent_nxt;
          // Busy was high on entry, so the first low sample is the falling edge.
          if (!I_busy) begin
            r_state      <= StGap;
            r_timer      <= '0;
            r_frames     <= r_frames + 32'd1;
            r_ident      <= r_ident + 16'd1;
            r_last_grant <= r_grant;
            if (w_sent_nxt < r_len) r_err <= 1'b1;
          end
        end
        StGap: begin
          if (r_timer == IFG_CYCLES - 1) begin
            r_state <= StIdle;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign O_en       = r_en;
  assign O_dataLen  = r_len;
  assign O_ipv4sign = r_ipv4sign;
  assign O_data     = r_data;
  assign O_grant    = r_grant;
  assign O_active   = (r_state != StIdle);
  assign O_err      = r_err;
  assign O_frames   = r_frames;

endmodule
